// File: rtl/memctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memctrl_pkg
//  Description : Shared types, constants and parity helper for the SRAM port
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package memctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RD_TURN  = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5
    } sram_state_t;

    localparam int DEFAULT_WAIT_CYCLES = 2;

    // Returns the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [15:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_wait_timer
//  Description : Loadable 4-bit down-counter with zero flag; paces the read
//                and write access phases.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign zero = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/sram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_ctrl
//  Description : Turns one-cycle read/write strobes into timed asynchronous
//                SRAM cycles with wait states and a read turnaround cycle.
//                Optional parity on the external bus: define SRAM_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_port_ctrl
    import memctrl_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              rsp_done,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              err_collision,
`ifdef SRAM_PARITY_EN
    output logic              rsp_perr,
    output logic [DATA_W:0]   sram_dq_o,
    input  logic [DATA_W:0]   sram_dq_i,
`else
    output logic [DATA_W-1:0] sram_dq_o,
    input  logic [DATA_W-1:0] sram_dq_i,
`endif
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

    sram_state_t r_state;
    logic        w_load;
    logic        w_dec;
    logic        w_zero;
    logic        w_strobe;

    assign w_strobe = req_rd | req_wr;
    assign w_load   = ((r_state == IDLE) && req_rd && !req_wr) || (r_state == WR_SETUP);
    assign w_dec    = (r_state == RD) || (r_state == WR_PULSE);

    sram_wait_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (c_wait),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            busy          <= 1'b0;
            rsp_done      <= 1'b0;
            rsp_rdata     <= '0;
            err_collision <= 1'b0;
            sram_addr     <= '0;
            sram_dq_o     <= '0;
            sram_dq_oe    <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
`ifdef SRAM_PARITY_EN
            rsp_perr      <= 1'b0;
`endif
        end else begin
            rsp_done      <= 1'b0;
            // Strobes while busy are dropped; in IDLE only rd+wr together is an error.
            err_collision <= (r_state != IDLE) ? w_strobe : (req_rd & req_wr);
`ifdef SRAM_PARITY_EN
            rsp_perr      <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (req_wr) begin
                        r_state    <= WR_SETUP;
                        busy       <= 1'b1;
                        sram_addr  <= req_addr;
`ifdef SRAM_PARITY_EN
                        sram_dq_o  <= {even_parity(16'(req_wdata)), req_wdata};
`else
                        sram_dq_o  <= req_wdata;
`endif
                        sram_ce_n  <= 1'b0;
                        sram_dq_oe <= 1'b1;
                    end else if (req_rd) begin
                        r_state   <= RD;
                        busy      <= 1'b1;
                        sram_addr <= req_addr;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                    end
                end
                RD: begin
                    if (w_zero) begin
                        r_state   <= RD_TURN;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        rsp_done  <= 1'b1;
                        rsp_rdata <= sram_dq_i[DATA_W-1:0];
`ifdef SRAM_PARITY_EN
                        rsp_perr  <= sram_dq_i[DATA_W] ^ even_parity(16'(sram_dq_i[DATA_W-1:0]));
`endif
                    end
                end
                RD_TURN: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                WR_SETUP: begin
                    r_state   <= WR_PULSE;
                    sram_we_n <= 1'b0;
                end
                WR_PULSE: begin
                    if (w_zero) begin
                        r_state   <= WR_HOLD;
                        sram_we_n <= 1'b1;
                        rsp_done  <= 1'b1;
                    end
                end
                WR_HOLD: begin
                    r_state    <= IDLE;
                    busy       <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    busy       <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_port_ctrl
//  Description : Randomised scoreboard bench for sram_port_ctrl with an SRAM
//                model and a cycle-window reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int W      = 2;
`ifdef SRAM_PARITY_EN
    localparam int EXT_W  = DATA_W + 1;
`else
    localparam int EXT_W  = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_rd = 1'b0;
    logic              req_wr = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              busy, rsp_done, err_collision;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [EXT_W-1:0]  sram_dq_o, sram_dq_i;
    logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
`ifdef SRAM_PARITY_EN
    logic              rsp_perr;
`endif

    sram_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_rd        (req_rd),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .busy          (busy),
        .rsp_done      (rsp_done),
        .rsp_rdata     (rsp_rdata),
        .err_collision (err_collision),
`ifdef SRAM_PARITY_EN
        .rsp_perr      (rsp_perr),
`endif
        .sram_dq_o     (sram_dq_o),
        .sram_dq_i     (sram_dq_i),
        .sram_addr     (sram_addr),
        .sram_dq_oe    (sram_dq_oe),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [EXT_W-1:0] mk_word(input logic [15:0] d);
`ifdef SRAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // SRAM model: 512 words, written while ce_n and we_n are both low.
    logic [EXT_W-1:0] sram_mem [0:511];
    logic             init_mem = 1'b1;
    logic             flip_req = 1'b0;
    logic [8:0]       flip_addr = '0;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 512; i++) sram_mem[i] <= mk_word(16'(i * 37 + 5));
        end else if (flip_req) begin
            sram_mem[flip_addr][EXT_W-1] <= ~sram_mem[flip_addr][EXT_W-1];
        end else if (!sram_ce_n && !sram_we_n) begin
            sram_mem[sram_addr[8:0]] <= sram_dq_o;
        end
    end
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[8:0]] : '0;

    // Reference model: expected memory contents and access windows.
    typedef struct { bit rd; logic [15:0] data; bit perr; } exp_t;
    exp_t        q[$];
    bit          exp_done[int];
    bit          exp_err[int];
    logic [15:0] ref_mem [0:511];
    bit          ref_flip [0:511];
    int          a_lo = 1, a_hi = 0;
    bit          a_wr = 1'b0;
    logic [15:0] a_addr = '0, a_data = '0;
    bit          mon_en = 1'b0;
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        int c;
        @(posedge clk); #1;
        rst = 1'b0; req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d;
        c = cyc;
        if (rd || wr) begin
            if (c >= a_lo && c <= a_hi) begin
                exp_err[c+1] = 1'b1;
            end else begin
                if (rd && wr) exp_err[c+1] = 1'b1;
                a_lo = c + 1; a_wr = wr; a_addr = a; a_data = d;
                if (wr) begin
                    a_hi = c + 3 + W;
                    ref_mem[a[8:0]]  = d;
                    ref_flip[a[8:0]] = 1'b0;
                    q.push_back('{1'b0, d, 1'b0});
                end else begin
                    a_hi = c + 2 + W;
                    q.push_back('{1'b1, ref_mem[a[8:0]], ref_flip[a[8:0]]});
                end
                exp_done[a_hi] = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // An aborted access loses its completion; outputs go idle after this cycle.
    task automatic reset_mid();
        int c;
        @(posedge clk); #1;
        rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0;
        c = cyc;
        if (a_hi > c) begin
            if (exp_done.exists(a_hi)) begin
                exp_done.delete(a_hi);
                void'(q.pop_back());
            end
            a_hi = c;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            int   c;
            bit   in_acc, oe_win, we_win;
            exp_t e;
            c      = cyc;
            in_acc = (c >= a_lo) && (c <= a_hi);
            oe_win = in_acc && !a_wr && (c <= a_lo + W);
            we_win = in_acc && a_wr && (c >= a_lo + 1) && (c <= a_lo + 1 + W);
            chk("busy",  32'(busy),       32'(in_acc));
            chk("ce_n",  32'(sram_ce_n),  32'(!(oe_win || (in_acc && a_wr))));
            chk("oe_n",  32'(sram_oe_n),  32'(!oe_win));
            chk("we_n",  32'(sram_we_n),  32'(!we_win));
            chk("dq_oe", 32'(sram_dq_oe), 32'(in_acc && a_wr));
            chk("err",   32'(err_collision), 32'(exp_err.exists(c)));
            chk("done",  32'(rsp_done),   32'(exp_done.exists(c)));
            if (in_acc) chk("addr", 32'(sram_addr), 32'(a_addr));
            if (in_acc && a_wr) chk("dq_o", 32'(sram_dq_o[15:0]), 32'(a_data));
            if (rsp_done) begin
                chk("sb_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    if (e.rd) chk("rdata", 32'(rsp_rdata), 32'(e.data));
`ifdef SRAM_PARITY_EN
                    chk("perr", 32'(rsp_perr), 32'(e.perr));
`endif
                end
            end
`ifdef SRAM_PARITY_EN
            else chk("perr_idle", 32'(rsp_perr), 32'd0);
`endif
        end
    end

    initial begin
        int          r;
        logic [15:0] a, d;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i]  = 16'(i * 37 + 5);
            ref_flip[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; init_mem = 1'b0; mon_en = 1'b1;
        chk("rst_addr",  32'(sram_addr),       32'd0);
        chk("rst_dq_o",  32'(sram_dq_o),       32'd0);
        chk("rst_rdata", 32'(rsp_rdata),       32'd0);

        idle(10);
        drive(1'b0, 1'b1, 16'h0081, 16'hA5C3);
        idle(7);
        chk("sram_hold", 32'(sram_mem[9'h081][15:0]), 32'hA5C3);
        drive(1'b1, 1'b0, 16'h0081, 16'h0);
        idle(6);

        drive(1'b1, 1'b1, 16'h0010, 16'h1234);
        idle(1);
        drive(1'b1, 1'b0, 16'h0020, 16'h0);
        idle(8);

        drive(1'b0, 1'b1, 16'h0030, 16'h5555);
        idle(2);
        reset_mid();
        idle(1);
        drive(1'b1, 1'b0, 16'h0081, 16'h0);
        idle(6);

`ifdef SRAM_PARITY_EN
        drive(1'b0, 1'b1, 16'h0040, 16'h0001);
        idle(7);
        flip_addr = 9'h040;
        flip_req  = 1'b1;
        idle(1);
        flip_req  = 1'b0;
        ref_flip[9'h040] = 1'b1;
        drive(1'b1, 1'b0, 16'h0040, 16'h0);
        idle(6);
        drive(1'b1, 1'b0, 16'h0081, 16'h0);
        idle(6);
`endif

        repeat (400) begin
            r = $urandom_range(0, 9);
            a = 16'(($urandom_range(0, 3) << 7) | $urandom_range(0, 7));
            d = 16'($urandom);
            drive(r <= 2 || r == 5, (r == 3) || (r == 4) || (r == 5), a, d);
        end
        idle(12);
        mon_en = 1'b0;
        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
